apb_stimulus_driver: RTL and testbench
======================================

APB_STIMULUS_DRIVER -- requirements
Module: apb_stimulus_driver

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, codeword data width; AMBA_ADDR_WIDTH, default 20, PADDR width; AMBA_WORD, default 32, APB data width; TIMEOUT_CYCLES, default 8, max cycles from CTRL write to operation_done.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  transaction request present.
REQ-006 req_ready  output  1  driver can accept a request; high only in IDLE.
REQ-007 req_ctrl  input  2  CTRL value: 0 encode, 1 decode, 2 full channel.
REQ-008 req_data  input  AMBA_WORD  DATA_IN register value.
REQ-009 req_width  input  2  CODEWORD_WIDTH register value.
REQ-010 req_noise  input  AMBA_WORD  NOISE register value.
REQ-011 PADDR  output  AMBA_ADDR_WIDTH  APB address; offsets CTRL 0x0, DATA_IN 0x4, CODEWORD_WIDTH 0x8, NOISE 0xC; upper bits 0.
REQ-012 PWDATA  output  AMBA_WORD  APB write data; req_ctrl/req_width zero-extended.
REQ-013 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-014 PRDATA  input  AMBA_WORD  APB read data from encoder/decoder.
REQ-015 operation_done  input  1  encoder/decoder completion.
REQ-016 txn_done  output  1  one-cycle pulse at transaction end.
REQ-017 timeout_err  output  1  sticky: operation_done not seen in time.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS, WAIT_DONE.
REQ-019 Request SHALL be accepted on a cycle with req_valid && req_ready; all req_* fields captured into registers that cycle.
REQ-020 Write order SHALL be DATA_IN, CODEWORD_WIDTH, NOISE, CTRL; CTRL always last.
REQ-021 Each access SHALL take 2 cycles: SETUP (PSEL=1, PENABLE=0), ACCESS (PSEL=1, PENABLE=1); PADDR/PWDATA/PWRITE stable across both.
REQ-022 Next SETUP SHALL follow previous ACCESS immediately; PSEL stays 1 across the sequence; 4 writes = 8 cycles after acceptance.
REQ-023 After CTRL ACCESS, FSM SHALL enter WAIT_DONE with PSEL=PENABLE=0 and a cycle counter cleared to 0.
REQ-024 In WAIT_DONE, operation_done=1 SHALL pulse txn_done next cycle and return to IDLE.
REQ-025 If counter reaches TIMEOUT_CYCLES without operation_done, timeout_err SHALL set, txn_done SHALL pulse, FSM returns to IDLE.
REQ-026 operation_done outside WAIT_DONE SHALL be ignored.
REQ-027 operation_done on the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success (no timeout_err).
REQ-028 timeout_err SHALL clear on the next accepted request.
REQ-029 req_valid while not req_ready SHALL be ignored; no request queuing.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, PADDR=0, PWDATA=0, PSEL=0, PENABLE=0, PWRITE=0, req_ready=1 (after release), txn_done=0, timeout_err=0, counter=0, even mid-access.

Configuration
REQ-031 Macro APB_READBACK_EN: when defined, after NOISE write and before CTRL write the driver SHALL read DATA_IN, CODEWORD_WIDTH, NOISE (PWRITE=0, 2 cycles each), compare PRDATA sampled in ACCESS against the written value, and set output readback_err (1 bit, sticky, cleared on next accept) on any mismatch; CTRL write proceeds regardless.
REQ-032 Without APB_READBACK_EN, no reads SHALL be issued, readback_err port SHALL not exist, sequence is 8 cycles.

Verification
REQ-033 Reset mid-ACCESS of NOISE write -> all APB outputs 0 same cycle, IDLE after release, no txn_done.
REQ-034 req_ctrl=0, req_data=0x0000_00A5, req_width=0, req_noise=0, operation_done 3 cycles after CTRL ACCESS -> writes at 0x4,0x8,0xC,0x0 in 8 cycles, txn_done 1 cycle, timeout_err=0.
REQ-035 operation_done never asserted, TIMEOUT_CYCLES=8 -> timeout_err=1 and txn_done at cycle 8 of WAIT_DONE; next accepted request clears timeout_err.
REQ-036 operation_done pulsed during DATA_IN write, then 2 cycles into WAIT_DONE -> first ignored, txn_done after second.
REQ-037 APB_READBACK_EN, PRDATA returns 0x0 for NOISE read after writing 0x0000_0003 -> readback_err=1, CTRL write still issued.
REQ-038 req_valid held high continuously -> next request accepted only in IDLE after txn_done, req_ready low throughout busy sequence.

Source files
------------

// File: rtl/apb_stimulus_driver.sv
// APB master that programs an encoder/decoder (DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL) and
// waits for operation_done. Defining APB_READBACK_EN adds a read-back check before the CTRL write.
module apb_stimulus_driver #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned AMBA_ADDR_WIDTH = 20,
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned TIMEOUT_CYCLES  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [1:0]                 req_ctrl,
   input  logic [AMBA_WORD-1:0]       req_data,
   input  logic [1:0]                 req_width,
   input  logic [AMBA_WORD-1:0]       req_noise,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   input  logic [AMBA_WORD-1:0]       PRDATA,
   input  logic                       operation_done,
   output logic                       txn_done,
`ifdef APB_READBACK_EN
   output logic                       readback_err,
`endif
   output logic                       timeout_err
);

   localparam int unsigned CntW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned DataBits = (DATA_WIDTH < AMBA_WORD) ? DATA_WIDTH : AMBA_WORD;
`ifdef APB_READBACK_EN
   localparam logic [2:0] LastStep = 3'd6;
`else
   localparam logic [2:0] LastStep = 3'd3;
`endif

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StWaitDone} state_e;
   // Encoded as the word index of the register, so PADDR = {reg_sel, 2'b00}.
   typedef enum logic [1:0] {RegCtrl = 2'd0, RegDataIn = 2'd1, RegWidth = 2'd2,
                             RegNoise = 2'd3} reg_e;

   state_e               state_q, state_d;
   logic [2:0]           step_q, step_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 txn_done_q, txn_done_d;
   logic                 timeout_q, timeout_d;
   logic [1:0]           ctrl_q, width_q;
   logic [AMBA_WORD-1:0] data_q, noise_q;
   logic [AMBA_WORD-1:0] data_mask;
   logic                 accept, busy, is_write;
   reg_e                 reg_sel;
   logic [AMBA_WORD-1:0] reg_val;

   // DATA_IN carries a DATA_WIDTH-bit codeword; bits above it are driven as zero.
   assign data_mask = {AMBA_WORD{1'b1}} >> (AMBA_WORD - DataBits);
   assign accept    = (state_q == StIdle) && req_valid;
   assign busy      = (state_q == StSetup) || (state_q == StAccess);

   always_comb begin
      reg_sel  = RegCtrl;
      is_write = 1'b1;
      unique case (step_q)
         3'd0: reg_sel = RegDataIn;
         3'd1: reg_sel = RegWidth;
         3'd2: reg_sel = RegNoise;
`ifdef APB_READBACK_EN
         3'd3: begin reg_sel = RegDataIn; is_write = 1'b0; end
         3'd4: begin reg_sel = RegWidth;  is_write = 1'b0; end
         3'd5: begin reg_sel = RegNoise;  is_write = 1'b0; end
`endif
         default: reg_sel = RegCtrl;
      endcase
   end

   always_comb begin
      reg_val = '0;
      unique case (reg_sel)
         RegDataIn: reg_val = data_q;
         RegWidth:  reg_val = AMBA_WORD'(width_q);
         RegNoise:  reg_val = noise_q;
         RegCtrl:   reg_val = AMBA_WORD'(ctrl_q);
         default:   reg_val = '0;
      endcase
   end

   assign req_ready   = (state_q == StIdle);
   assign PSEL        = busy;
   assign PENABLE     = (state_q == StAccess);
   assign PWRITE      = busy && is_write;
   assign PADDR       = busy ? AMBA_ADDR_WIDTH'({reg_sel, 2'b00}) : '0;
   assign PWDATA      = (busy && is_write) ? reg_val : '0;
   assign txn_done    = txn_done_q;
   assign timeout_err = timeout_q;

`ifdef APB_READBACK_EN
   logic rb_err_q, rb_err_d;
   assign readback_err = rb_err_q;
`else
   logic unused_prdata;
   assign unused_prdata = ^PRDATA;
`endif

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      cnt_d      = cnt_q;
      txn_done_d = 1'b0;
      timeout_d  = timeout_q;
`ifdef APB_READBACK_EN
      rb_err_d   = rb_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d   = StSetup;
               step_d    = 3'd0;
               timeout_d = 1'b0;
`ifdef APB_READBACK_EN
               rb_err_d  = 1'b0;
`endif
            end
         end
         StSetup: state_d = StAccess;
         StAccess: begin
`ifdef APB_READBACK_EN
            if (!is_write && (PRDATA != reg_val)) rb_err_d = 1'b1;
`endif
            if (step_q == LastStep) begin
               state_d = StWaitDone;
               cnt_d   = '0;
            end else begin
               state_d = StSetup;
               step_d  = step_q + 3'd1;
            end
         end
         StWaitDone: begin
            // A completion on the final counted cycle still wins over the timeout.
            if (operation_done) begin
               state_d    = StIdle;
               txn_done_d = 1'b1;
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
               state_d    = StIdle;
               txn_done_d = 1'b1;
               timeout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         step_q     <= '0;
         cnt_q      <= '0;
         txn_done_q <= 1'b0;
         timeout_q  <= 1'b0;
`ifdef APB_READBACK_EN
         rb_err_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         cnt_q      <= cnt_d;
         txn_done_q <= txn_done_d;
         timeout_q  <= timeout_d;
`ifdef APB_READBACK_EN
         rb_err_q   <= rb_err_d;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q  <= '0;
         width_q <= '0;
         data_q  <= '0;
         noise_q <= '0;
      end else if (accept) begin
         ctrl_q  <= req_ctrl;
         width_q <= req_width;
         data_q  <= req_data & data_mask;
         noise_q <= req_noise;
      end
   end

endmodule

// File: tb/tb_apb_stimulus_driver.sv
// Scoreboard bench for apb_stimulus_driver: expected APB accesses and completions are queued at
// issue time and checked by a monitor against cycle numbers counted from request acceptance.
module tb_apb_stimulus_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_ctrl;
   logic [31:0] req_data;
   logic [1:0]  req_width;
   logic [31:0] req_noise;
   logic [19:0] PADDR;
   logic [31:0] PWDATA;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PRDATA;
   logic        operation_done;
   logic        txn_done;
   logic        timeout_err;
`ifdef APB_READBACK_EN
   logic        readback_err;
   localparam int W = 14;
`else
   localparam int W = 8;
`endif

   apb_stimulus_driver dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_ctrl       (req_ctrl),
      .req_data       (req_data),
      .req_width      (req_width),
      .req_noise      (req_noise),
      .PADDR          (PADDR),
      .PWDATA         (PWDATA),
      .PSEL           (PSEL),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PRDATA         (PRDATA),
      .operation_done (operation_done),
      .txn_done       (txn_done),
`ifdef APB_READBACK_EN
      .readback_err   (readback_err),
`endif
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave register model; corrupt_noise forces NOISE reads to return zero.
   logic [31:0] mem [4] = '{default: 32'h0};
   logic        corrupt_noise = 1'b0;
   always @(posedge clk)
      if (PSEL && PENABLE && PWRITE) mem[PADDR[3:2]] <= PWDATA;
   assign PRDATA = (corrupt_noise && PADDR[3:2] == 2'd3) ? 32'h0 : mem[PADDR[3:2]];

   typedef struct { int cyc; logic [19:0] addr; logic [31:0] data; logic wr; } apb_exp_t;
   typedef struct { int cyc; logic to; logic rb; } txn_exp_t;
   apb_exp_t apb_q[$];
   txn_exp_t txn_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      apb_exp_t ea;
      txn_exp_t et;
      if (rst) begin
         if (PSEL && PENABLE) begin
            if (apb_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_apb: access to 0x%0h at cycle %0d, none required",
                        PADDR, cyc);
            end else begin
               ea = apb_q.pop_front();
               check("apb_cycle", cyc, ea.cyc);
               check("apb_addr", PADDR, ea.addr);
               check("apb_write", PWRITE, ea.wr);
               if (ea.wr) check("apb_wdata", PWDATA, ea.data);
            end
         end
         if (txn_done) begin
            if (txn_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_txn_done: pulse at cycle %0d, none required", cyc);
            end else begin
               et = txn_q.pop_front();
               check("txn_cycle", cyc, et.cyc);
               check("txn_timeout_err", timeout_err, et.to);
`ifdef APB_READBACK_EN
               check("txn_readback_err", readback_err, et.rb);
`endif
            end
         end
      end
   end

   task automatic push1(input int c, input logic [19:0] a, input logic [31:0] d, input logic wr);
      apb_exp_t e;
      e.cyc = c; e.addr = a; e.data = d; e.wr = wr;
      apb_q.push_back(e);
   endtask

   // Accesses land on the ACCESS cycles a+1, a+3, ... after acceptance at edge a.
   task automatic push_apb(input int a, input logic [1:0] c, input logic [31:0] d,
                           input logic [1:0] w, input logic [31:0] n, input int n_items);
      if (n_items > 0) push1(a + 1, 20'h4, d, 1'b1);
      if (n_items > 1) push1(a + 3, 20'h8, {30'b0, w}, 1'b1);
      if (n_items > 2) push1(a + 5, 20'hC, n, 1'b1);
`ifdef APB_READBACK_EN
      if (n_items > 3) begin
         push1(a + 7, 20'h4, 32'h0, 1'b0);
         push1(a + 9, 20'h8, 32'h0, 1'b0);
         push1(a + 11, 20'hC, 32'h0, 1'b0);
      end
`endif
      if (n_items > 3) push1(a + W - 1, 20'h0, {30'b0, c}, 1'b1);
   endtask

   task automatic push_txn(input int c, input logic to, input logic rb);
      txn_exp_t e;
      e.cyc = c; e.to = to; e.rb = rb;
      txn_q.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Called at a negedge; returns the edge number at which the request is accepted.
   task automatic issue(input logic [1:0] c, input logic [31:0] d, input logic [1:0] w,
                        input logic [31:0] n, output int a);
      int tries = 0;
      req_ctrl = c; req_data = d; req_width = w; req_noise = n; req_valid = 1'b1;
      while (!req_ready && tries < 60) begin
         @(negedge clk);
         tries++;
      end
      if (!req_ready) begin
         n_tests++; n_fail++;
         $display("FAIL accept_wait: req_ready still 0 after %0d cycles, required 1", tries);
      end
      a = cyc + 1;
   endtask

   task automatic release_req();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic pulse_done(input int c);
      wait_cyc(c);
      operation_done = 1'b1;
      @(negedge clk);
      operation_done = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int a, a2, bad;
      rst = 1'b0; req_valid = 1'b0; req_ctrl = '0; req_data = '0; req_width = '0;
      req_noise = '0; operation_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_psel", PSEL, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_req_ready", req_ready, 1);
      check("idle_pwrite", PWRITE, 0);
      check("idle_txn_done", txn_done, 0);
      check("idle_timeout_err", timeout_err, 0);

      // Basic encode, completion two cycles into WAIT_DONE.
      issue(2'd0, 32'h0000_00A5, 2'd0, 32'h0, a);
      push_apb(a, 2'd0, 32'h0000_00A5, 2'd0, 32'h0, 4);
      push_txn(a + W + 3, 1'b0, 1'b0);
      release_req();
      pulse_done(a + W + 2);
      wait_cyc(a + W + 5);

      // Full channel, completion on the first WAIT_DONE cycle.
      issue(2'd2, 32'hDEAD_BEEF, 2'd3, 32'h0000_0003, a);
      push_apb(a, 2'd2, 32'hDEAD_BEEF, 2'd3, 32'h0000_0003, 4);
      push_txn(a + W + 1, 1'b0, 1'b0);
      release_req();
      pulse_done(a + W);
      wait_cyc(a + W + 3);

      // Early operation_done during the DATA_IN write is ignored.
      issue(2'd1, 32'h0000_1234, 2'd1, 32'h0000_0005, a);
      push_apb(a, 2'd1, 32'h0000_1234, 2'd1, 32'h0000_0005, 4);
      push_txn(a + W + 3, 1'b0, 1'b0);
      operation_done = 1'b1;
      release_req();
      operation_done = 1'b0;
      pulse_done(a + W + 2);
      wait_cyc(a + W + 5);

      // No completion: timeout after the counter reaches 8.
      issue(2'd0, 32'hFFFF_FFFF, 2'd2, 32'h8000_0001, a);
      push_apb(a, 2'd0, 32'hFFFF_FFFF, 2'd2, 32'h8000_0001, 4);
      push_txn(a + W + 9, 1'b1, 1'b0);
      release_req();
      wait_cyc(a + W + 12);
      check("timeout_sticky", timeout_err, 1);

      // Next accept clears timeout_err; completion on the timeout cycle counts as success.
      issue(2'd2, 32'h0000_0000, 2'd1, 32'h0000_00F0, a);
      push_apb(a, 2'd2, 32'h0000_0000, 2'd1, 32'h0000_00F0, 4);
      push_txn(a + W + 9, 1'b0, 1'b0);
      release_req();
      check("timeout_clear_on_accept", timeout_err, 0);
      pulse_done(a + W + 8);
      wait_cyc(a + W + 11);

      // req_valid held high: second request only taken once the first has completed.
      issue(2'd1, 32'h0000_0F0F, 2'd3, 32'h0000_0011, a);
      push_apb(a, 2'd1, 32'h0000_0F0F, 2'd3, 32'h0000_0011, 4);
      push_txn(a + W + 1, 1'b0, 1'b0);
      bad = 0;
      for (int c = a; c <= a + W; c++) begin
         wait_cyc(c);
         if (c == a) begin
            req_ctrl = 2'd2; req_data = 32'hCAFE_0001; req_width = 2'd2; req_noise = 32'h0000_0100;
         end
         if (req_ready) bad++;
         if (c == a + W) operation_done = 1'b1;
      end
      wait_cyc(a + W + 1);
      operation_done = 1'b0;
      check("req_ready_low_while_busy", bad, 0);
      a2 = a + W + 2;
      push_apb(a2, 2'd2, 32'hCAFE_0001, 2'd2, 32'h0000_0100, 4);
      push_txn(a2 + W + 2, 1'b0, 1'b0);
      wait_cyc(a2);
      req_valid = 1'b0;
      pulse_done(a2 + W + 1);
      wait_cyc(a2 + W + 4);

      // Reset during the NOISE ACCESS phase.
      issue(2'd1, 32'h0000_0055, 2'd1, 32'h0000_0077, a);
      push_apb(a, 2'd1, 32'h0000_0055, 2'd1, 32'h0000_0077, 3);
      release_req();
      wait_cyc(a + 5);
      #2 rst = 1'b0;
      #1;
      check("midrst_psel", PSEL, 0);
      check("midrst_penable", PENABLE, 0);
      check("midrst_pwrite", PWRITE, 0);
      check("midrst_paddr", PADDR, 0);
      check("midrst_pwdata", PWDATA, 0);
      check("midrst_txn_done", txn_done, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("postrst_req_ready", req_ready, 1);
      check("postrst_psel", PSEL, 0);
      repeat (W + 12) @(negedge clk);

`ifdef APB_READBACK_EN
      // NOISE read returns zero: readback_err set, CTRL write still issued.
      corrupt_noise = 1'b1;
      issue(2'd0, 32'h0000_0011, 2'd2, 32'h0000_0003, a);
      push_apb(a, 2'd0, 32'h0000_0011, 2'd2, 32'h0000_0003, 4);
      push_txn(a + W + 1, 1'b0, 1'b1);
      release_req();
      pulse_done(a + W);
      wait_cyc(a + W + 3);
      corrupt_noise = 1'b0;
`endif

      repeat (5) @(negedge clk);
      check("apb_queue_drained", apb_q.size(), 0);
      check("txn_queue_drained", txn_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
